ahb_sram_ctrl: RTL
==================

// Module: ahb_sram_ctrl
// PURPOSE
//  SRAM control stage downstream of the AHB slave interface. Accepts one-cycle
//  ahbsram_req pulses, decodes HSIZE/address into byte lanes, and accesses an
//  internal word-organised single-port synchronous array with configurable read
//  latency. Returns a one-cycle sramahb_ack plus read data to the AHB interface.
// PARAMETERS
//  SIZE_IN_BYTES  2048                     array capacity in bytes; power of 2, >=8
//  ADD_WIDTH      $clog2(SIZE_IN_BYTES)    byte-address width
//  READ_LAT       1                        array read latency in cycles, 1..4
// PORTS
//  HCLK           in   1          clock, all logic on rising edge
//  aresetn        in   1          asynchronous active-low reset
//  ahbsram_req    in   1          one-cycle access request
//  ahbsram_write  in   1          1 = write, 0 = read; valid with req
//  ahbsram_wdata  in   32         write data, AHB lane-positioned; valid with req
//  ahbsram_size   in   3          0 = byte, 1 = half, 2 = word, >2 = treated as word
//  ahbsram_addr   in   ADD_WIDTH  byte address; valid with req
//  sramahb_ack    out  1          one-cycle completion pulse
//  sramahb_rdata  out  32         read word; valid with read ack, held until next read ack
//  busy           out  1          access in progress (state != IDLE)
//  misalign_err   out  1          one-cycle pulse with ack when access was misaligned
//  drop_err       out  1          one-cycle pulse when req arrives while busy
// BEHAVIOUR
//  Reset (async, aresetn=0): state IDLE; sramahb_ack, busy, misalign_err, drop_err
//   = 0; sramahb_rdata = 0; read counter = 0. Array contents are not cleared.
//  Capture: in IDLE, req=1 latches write, wdata, size, addr, and byte enables
//   (be) in the same cycle. Word index = addr[ADD_WIDTH-1:2], 2^(ADD_WIDTH-2) words.
//  Lane decode: byte be=4'b0001<<addr[1:0]; half be=addr[1]?4'b1100:4'b0011;
//   word be=4'b1111. Lane i writes wdata[8i+7:8i]. Data is not shifted.
//  Misaligned (half with addr[0]=1, word with addr[1:0]!=0): still executed with the
//   aligned-down lanes above; misalign_err=1 in the ack cycle. size>2 does not flag.
//  FSM states:
//   IDLE  -> WR on req&write; -> RD on req&!write. busy=0.
//   WR    -> array lanes in be written this cycle; ack=1; -> IDLE. Write latency is
//            1 cycle: req at cycle N, ack at N+1.
//   RD    -> counter cnt counts up from 1; on cnt==READ_LAT the full word is loaded
//            into sramahb_rdata; ack=1; -> IDLE. req at cycle N, ack at N+READ_LAT.
//  Back-to-back: req is accepted in IDLE only. The ack cycle returns to IDLE, so the
//   earliest next req is the cycle after ack.
//  req while busy (including the ack cycle): ignored, no state change, drop_err=1
//   for one cycle.
//  Read returns the whole 32-bit word regardless of size; lane selection is the
//   master's responsibility. Write-then-read of the same address returns new data.
//  Reset mid-operation: pending access is abandoned with no ack and no further array
//   write. A write already in WR state is either fully committed or not at all;
//   partial lanes are never allowed.
//  Address above array range cannot occur; ADD_WIDTH bits only.
// TESTING
//  1 Word write addr 0x010 data 0xDEADBEEF, then read 0x010 -> ack 1 cyc after
//    write req; read ack at req+READ_LAT with rdata 0xDEADBEEF.
//  2 Byte write addr 0x011 data 0x0000AA00, half write addr 0x012 data 0x12340000,
//    then read word 0x010 -> 0x1234AAEF.
//  3 READ_LAT=3: read req at cycle 10 -> ack exactly at cycle 13; busy=1 on cycles
//    11-13; rdata unchanged before cycle 13.
//  4 Misaligned word write addr 0x016 data 0xCAFEF00D -> word 0x014 = 0xCAFEF00D;
//    misalign_err=1 with ack only.
//  5 req asserted in WR/RD or in the ack cycle -> drop_err pulse, no extra ack,
//    memory unchanged.
//  6 aresetn low during RD (READ_LAT=4) -> no ack, rdata=0, busy=0; subsequent read
//    returns prior array contents.

Source files
------------

// File: rtl/ahb_sram_if.sv
// AHB-side request/response bundle for the SRAM control stage.
// The master drives the request fields and the slave returns completion and status.
interface ahb_sram_if #(
  parameter int ADD_WIDTH = 11
);
  logic                 ahbsram_req;
  logic                 ahbsram_write;
  logic [31:0]          ahbsram_wdata;
  logic [2:0]           ahbsram_size;
  logic [ADD_WIDTH-1:0] ahbsram_addr;
  logic                 sramahb_ack;
  logic [31:0]          sramahb_rdata;
  logic                 busy;
  logic                 misalign_err;
  logic                 drop_err;

  modport master (
    output ahbsram_req, ahbsram_write,
    output ahbsram_wdata, ahbsram_size,
    output ahbsram_addr,
    input  sramahb_ack, sramahb_rdata,
    input  busy, misalign_err, drop_err
  );

  modport slave (
    input  ahbsram_req, ahbsram_write,
    input  ahbsram_wdata, ahbsram_size,
    input  ahbsram_addr,
    output sramahb_ack, sramahb_rdata,
    output busy, misalign_err, drop_err
  );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// SRAM control stage: lane decode, word-wide single-port array access,
// configurable read latency, and a one-cycle ack back to the AHB side.
module ahb_sram_ctrl #(
  parameter int SIZE_IN_BYTES = 2048,
  parameter int ADD_WIDTH     = $clog2(SIZE_IN_BYTES),
  parameter int READ_LAT      = 1
) (
  input logic        HCLK,
  input logic        aresetn,
  ahb_sram_if.slave  bus
);
  localparam int WORDS = SIZE_IN_BYTES / 4;
  localparam int WAW   = ADD_WIDTH - 2;
  localparam logic [2:0] LAT = 3'(READ_LAT);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [WAW-1:0]  idx_q, idx_d;
  logic            mis_q, mis_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            merr_q, merr_d;
  logic            drop_q, drop_d;

  logic [31:0]     mem [WORDS];
  logic [3:0]      be_n;
  logic            mis_n;
  logic            rd_en;
  logic [WAW-1:0]  rd_idx;

  logic [1:0] a_lo;
  logic       sz_b;
  logic       sz_h;
  logic       sz_w;

  assign a_lo = bus.ahbsram_addr[1:0];
  assign sz_b = bus.ahbsram_size == 3'd0;
  assign sz_h = bus.ahbsram_size == 3'd1;
  assign sz_w = bus.ahbsram_size == 3'd2;

  // Misaligned accesses still run, using the aligned-down lanes.
  always_comb begin
    be_n  = 4'b1111;
    mis_n = 1'b0;
    unique case (1'b1)
      sz_b: be_n = 4'b0001 << a_lo;
      sz_h: begin
        be_n  = a_lo[1] ? 4'b1100 : 4'b0011;
        mis_n = a_lo[0];
      end
      sz_w: mis_n = |a_lo;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    merr_d  = 1'b0;
    drop_d  = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ahbsram_req) begin
          wdata_d = bus.ahbsram_wdata;
          be_d    = be_n;
          idx_d   = bus.ahbsram_addr[ADD_WIDTH-1:2];
          mis_d   = mis_n;
          cnt_d   = 3'd1;
          if (bus.ahbsram_write) begin
            state_d = WR;
            ack_d   = 1'b1;
            merr_d  = mis_n;
          end else begin
            state_d = RD;
            if (LAT == 3'd1) begin
              ack_d  = 1'b1;
              merr_d = mis_n;
              rd_en  = 1'b1;
            end
          end
        end
      end
      WR: begin
        drop_d  = bus.ahbsram_req;
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
      RD: begin
        drop_d = bus.ahbsram_req;
        if (cnt_q == LAT) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          // Load one cycle early so data and ack are registered together.
          if (cnt_q + 3'd1 == LAT) begin
            ack_d  = 1'b1;
            merr_d = mis_q;
            rd_en  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_idx  = (state_q == IDLE) ?
                   bus.ahbsram_addr[ADD_WIDTH-1:2] : idx_q;
  assign rdata_d = rd_en ? mem[rd_idx] : rdata_q;

  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      wdata_q <= '0;
      be_q    <= '0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      merr_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      merr_q  <= merr_d;
      drop_q  <= drop_d;
    end
  end

  // All enabled lanes commit on one edge, so a write is never partial.
  always_ff @(posedge HCLK) begin
    if (state_q == WR) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.sramahb_ack   = ack_q;
  assign bus.sramahb_rdata = rdata_q;
  assign bus.busy          = state_q != IDLE;
  assign bus.misalign_err  = merr_q;
  assign bus.drop_err      = drop_q;
endmodule
